systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have these parameters:
- ROWS, 2, number of A lanes
- COLUMNS, 2, number of B lanes
- WIDTH, 8, bits per lane
- DEPTH, 4, beats per operand frame (inner dimension K)
REQ-002 The block SHALL have these ports:
- clock  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_a  input  ROWS*WIDTH  A column slice; lane i at bits [(i+1)*WIDTH-1 -: WIDTH]
- in_b  input  COLUMNS*WIDTH  B row slice; lane j at bits [(j+1)*WIDTH-1 -: WIDTH]
- out_a  output  ROWS*WIDTH  skewed A lanes to the systolic array, same packing
- out_b  output  COLUMNS*WIDTH  skewed B lanes to the systolic array, same packing
- out_valid  output  1  at least one output lane carries frame data
- busy  output  1  frame in progress, state other than IDLE
- done  output  1  one-cycle pulse when the last lane of the frame is presented

Function
REQ-003 The block SHALL define M = max(ROWS, COLUMNS) - 1 as the flush length.
REQ-004 The block SHALL implement four states: IDLE, STREAM, FLUSH, DONE.
REQ-005 The block SHALL accept a beat on any rising edge where in_valid = 1 and in_ready = 1.
REQ-006 in_ready SHALL be 1 in IDLE and STREAM, and 0 in FLUSH and DONE.
REQ-007 In IDLE, an accepted beat SHALL be beat 0 of a new frame and SHALL move the block to STREAM, or to FLUSH/DONE per REQ-009 when DEPTH = 1.
REQ-008 A beat counter SHALL count accepted beats 0..DEPTH-1 and SHALL clear when a frame completes.
REQ-009 On acceptance of beat DEPTH-1, the next state SHALL be FLUSH if M > 0 and DONE if M = 0.
REQ-010 FLUSH SHALL last exactly M cycles, after which the block SHALL move to DONE.
REQ-011 DONE SHALL last exactly one cycle, with done = 1, after which the block SHALL move to IDLE.
REQ-012 A lane i SHALL have a register chain of depth i+1, with stage 0 loaded from the input and out lane i driven from stage i; this applies to A lane i and B lane j alike.
REQ-013 Each chain stage SHALL carry a 1-bit valid tag that shifts with the data.
REQ-014 Stage 0 SHALL load the input lane with tag 1 on an accepted beat, and SHALL load zero with tag 0 otherwise (IDLE, STREAM bubble, FLUSH, DONE).
REQ-015 A-lane i input data SHALL appear on out_a lane i exactly i+1 cycles after acceptance; B lanes SHALL follow the same rule with index j.
REQ-016 out_valid SHALL be the OR of all output-stage tags; out lanes with tag 0 SHALL read zero.
REQ-017 STREAM bubbles (in_valid = 0) SHALL insert zero wavefront entries without changing state or the beat counter.
REQ-018 The done pulse SHALL coincide with the cycle in which the final beat's lane M is presented.
REQ-019 in_valid asserted while in_ready = 0 SHALL be ignored, and no data SHALL be captured.
REQ-020 All outputs SHALL be registered or decoded from the state register only, with no combinational path from in_valid to in_ready.
REQ-021 The block SHALL pass data through unchanged, with no arithmetic; widths SHALL be preserved.

Reset
REQ-022 While reset = 0, all chain data, tags, counter and state SHALL clear asynchronously: state IDLE, out_a = 0, out_b = 0, out_valid = 0, busy = 0, done = 0, in_ready = 1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no done pulse; the first beat accepted after release SHALL be beat 0.

Verification
REQ-024 Parameters ROWS = COLUMNS = 2, WIDTH = 8, DEPTH = 2. Back-to-back beats at cycles 0 and 1: beat 0 a = {02,01}, b = {04,03}; beat 1 a = {06,05}, b = {08,07}. Required:
- cycle 1: out_a = {00,01}, out_b = {00,03}
- cycle 2: out_a = {02,05}, out_b = {04,07}
- cycle 3: out_a = {06,00}, out_b = {08,00}, done = 1
- cycle 4: all outputs zero, busy = 0
REQ-025 Same frame with in_valid = 0 at cycle 1 and beat 1 at cycle 2 -> every output shifts one cycle later, a zero wavefront entry appears at cycle 2, and done occurs at cycle 4.
REQ-026 in_valid held high during FLUSH/DONE with a = {FF,FF} -> no capture, FF never appears on any output, and the next frame starts in IDLE.
REQ-027 Reset pulsed at cycle 2 of REQ-024 -> all outputs 0 immediately, no done pulse; a new frame after release matches REQ-024 timing.
REQ-028 ROWS = COLUMNS = 1, DEPTH = 1, beat a = 5A, b = A5 at cycle 0 -> cycle 1: out_a = 5A, out_b = A5, done = 1, out_valid = 1; cycle 2: IDLE.
REQ-029 ROWS = 3, COLUMNS = 1, DEPTH = 1 -> FLUSH lasts 2 cycles, out_a lane 2 valid at cycle 3 coincides with done, and out_b is valid only at cycle 1.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Skews A and B operand lanes into a diagonal wavefront for a systolic array.
// Lane k is delayed k+1 cycles; a FLUSH tail drains the longest chain before done.
module systolic_skew_feeder #(
   parameter int ROWS    = 2,
   parameter int COLUMNS = 2,
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROWS*WIDTH-1:0]      in_a,
   input  logic [COLUMNS*WIDTH-1:0]   in_b,
   output logic [ROWS*WIDTH-1:0]      out_a,
   output logic [COLUMNS*WIDTH-1:0]   out_b,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       done
);

   localparam int M  = ((ROWS > COLUMNS) ? ROWS : COLUMNS) - 1;
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] BEAT_LAST  = CW'(DEPTH - 1);
   localparam logic [FW-1:0] FLUSH_LAST = (M > 0) ? FW'(M - 1) : '0;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic          accept;
   logic [ROWS-1:0]    a_tag;
   logic [COLUMNS-1:0] b_tag;

   // Handshake and status decode from state only, never from in_valid.
   assign in_ready  = (state_q == IDLE) || (state_q == STREAM);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign out_valid = |{a_tag, b_tag};

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE, STREAM: begin
            if (accept) begin
               if (beat_cnt_q == BEAT_LAST) begin
                  beat_cnt_d  = '0;
                  flush_cnt_d = '0;
                  state_d     = (M > 0) ? FLUSH : DONE;
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
                  state_d    = STREAM;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) state_d = DONE;
            else flush_cnt_d = flush_cnt_q + FW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Stage 0 loads zero with tag 0 when nothing is accepted, so untagged data always reads zero.
   for (genvar i = 0; i < ROWS; i++) begin : g_a
      logic [i:0][WIDTH-1:0] dat_q, dat_d;
      logic [i:0]            tag_q, tag_d;

      always_comb begin
         dat_d[0] = accept ? in_a[(i+1)*WIDTH-1 -: WIDTH] : '0;
         tag_d[0] = accept;
         for (int s = 1; s <= i; s++) begin
            dat_d[s] = dat_q[s-1];
            tag_d[s] = tag_q[s-1];
         end
      end

      // NOTE: the skew chains are plain flops, cleared on reset so an abandoned frame never leaks out.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            dat_q <= '0;
            tag_q <= '0;
         end else begin
            dat_q <= dat_d;
            tag_q <= tag_d;
         end
      end

      assign out_a[(i+1)*WIDTH-1 -: WIDTH] = dat_q[i];
      assign a_tag[i] = tag_q[i];
   end

   for (genvar j = 0; j < COLUMNS; j++) begin : g_b
      logic [j:0][WIDTH-1:0] dat_q, dat_d;
      logic [j:0]            tag_q, tag_d;

      always_comb begin
         dat_d[0] = accept ? in_b[(j+1)*WIDTH-1 -: WIDTH] : '0;
         tag_d[0] = accept;
         for (int s = 1; s <= j; s++) begin
            dat_d[s] = dat_q[s-1];
            tag_d[s] = tag_q[s-1];
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            dat_q <= '0;
            tag_q <= '0;
         end else begin
            dat_q <= dat_d;
            tag_q <= tag_d;
         end
      end

      assign out_b[(j+1)*WIDTH-1 -: WIDTH] = dat_q[j];
      assign b_tag[j] = tag_q[j];
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: 2x2/DEPTH=2, 1x1/DEPTH=1 and 3x1/DEPTH=1 instances.
// Outputs are sampled 1 time unit after each rising edge; flags are {out_valid, busy, done, in_ready}.
module tb_systolic_skew_feeder;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // 2x2, DEPTH=2 instance
   logic        in_valid, in_ready, out_valid, busy, done;
   logic [15:0] in_a, in_b, out_a, out_b;
   // 1x1, DEPTH=1 instance
   logic        in_valid1, in_ready1, out_valid1, busy1, done1;
   logic [7:0]  in_a1, in_b1, out_a1, out_b1;
   // 3x1, DEPTH=1 instance
   logic        in_valid3, in_ready3, out_valid3, busy3, done3;
   logic [23:0] in_a3, out_a3;
   logic [7:0]  in_b3, out_b3;

   systolic_skew_feeder #(.ROWS(2), .COLUMNS(2), .WIDTH(8), .DEPTH(2)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_a(out_a), .out_b(out_b),
      .out_valid(out_valid), .busy(busy), .done(done));

   systolic_skew_feeder #(.ROWS(1), .COLUMNS(1), .WIDTH(8), .DEPTH(1)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .out_a(out_a1), .out_b(out_b1),
      .out_valid(out_valid1), .busy(busy1), .done(done1));

   systolic_skew_feeder #(.ROWS(3), .COLUMNS(1), .WIDTH(8), .DEPTH(1)) dut3 (
      .clock(clock), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_a(in_a3), .in_b(in_b3), .out_a(out_a3), .out_b(out_b3),
      .out_valid(out_valid3), .busy(busy3), .done(done3));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      checks++;
      if ({out_a, out_b} !== 32'h0) begin
         errors++; $display("FAIL reset_data got %h expected %h", {out_a, out_b}, 32'h0);
      end
      checks++;
      if ({out_valid, busy, done, in_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_flags got %b expected %b", {out_valid, busy, done, in_ready}, 4'b0001);
      end
      checks++;
      if ({out_valid1, busy1, done1, in_ready1, out_valid3, busy3, done3, in_ready3} !== 8'b0001_0001) begin
         errors++; $display("FAIL reset_small_flags got %b expected %b",
            {out_valid1, busy1, done1, in_ready1, out_valid3, busy3, done3, in_ready3}, 8'b0001_0001);
      end
      reset = 1'b1;
      step();
   endtask

   // Two-beat frame; with junk set, in_valid is held high with FF data during FLUSH and DONE.
   task automatic test_back_to_back(input bit junk, input string name);
      logic [31:0] ed [1:4] = '{32'h0001_0003, 32'h0205_0407, 32'h0600_0800, 32'h0000_0000};
      logic [3:0]  ef [1:4] = '{4'b1101, 4'b1100, 4'b1110, 4'b0001};
      in_valid = 1'b1; in_a = 16'h0201; in_b = 16'h0403;
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if ({out_a, out_b} !== ed[c]) begin
            errors++; $display("FAIL %s c%0d data got %h expected %h", name, c, {out_a, out_b}, ed[c]);
         end
         checks++;
         if ({out_valid, busy, done, in_ready} !== ef[c]) begin
            errors++; $display("FAIL %s c%0d flags got %b expected %b", name, c, {out_valid, busy, done, in_ready}, ef[c]);
         end
         if (c == 1) begin
            in_valid = 1'b1; in_a = 16'h0605; in_b = 16'h0807;
         end else if ((c == 2 || c == 3) && junk) begin
            in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
         end else begin
            in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
         end
      end
   endtask

   task automatic test_bubble();
      logic [31:0] ed [1:5] = '{32'h0001_0003, 32'h0200_0400, 32'h0005_0007, 32'h0600_0800, 32'h0};
      logic [3:0]  ef [1:5] = '{4'b1101, 4'b1101, 4'b1100, 4'b1110, 4'b0001};
      in_valid = 1'b1; in_a = 16'h0201; in_b = 16'h0403;
      for (int c = 1; c <= 5; c++) begin
         step();
         checks++;
         if ({out_a, out_b} !== ed[c]) begin
            errors++; $display("FAIL bubble c%0d data got %h expected %h", c, {out_a, out_b}, ed[c]);
         end
         checks++;
         if ({out_valid, busy, done, in_ready} !== ef[c]) begin
            errors++; $display("FAIL bubble c%0d flags got %b expected %b", c, {out_valid, busy, done, in_ready}, ef[c]);
         end
         in_valid = (c == 2);
         in_a = (c == 2) ? 16'h0605 : 16'h0;
         in_b = (c == 2) ? 16'h0807 : 16'h0;
      end
   endtask

   task automatic test_reset_mid_frame();
      in_valid = 1'b1; in_a = 16'h0201; in_b = 16'h0403;
      step();
      in_a = 16'h0605; in_b = 16'h0807;
      step();
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if ({out_a, out_b, out_valid, busy, done, in_ready} !== 36'h0_0000_0001) begin
         errors++; $display("FAIL reset_mid immediate got %h expected %h",
            {out_a, out_b, out_valid, busy, done, in_ready}, 36'h0_0000_0001);
      end
      step();
      checks++;
      if ({out_a, out_b, out_valid, busy, done, in_ready} !== 36'h0_0000_0001) begin
         errors++; $display("FAIL reset_mid held got %h expected %h",
            {out_a, out_b, out_valid, busy, done, in_ready}, 36'h0_0000_0001);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({out_valid, busy, done, in_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_mid released flags got %b expected %b", {out_valid, busy, done, in_ready}, 4'b0001);
      end
      test_back_to_back(1'b0, "after_reset");
   endtask

   task automatic test_single_lane();
      in_valid1 = 1'b1; in_a1 = 8'h5A; in_b1 = 8'hA5;
      step();
      in_valid1 = 1'b0; in_a1 = 8'h0; in_b1 = 8'h0;
      checks++;
      if ({out_a1, out_b1} !== 16'h5AA5) begin
         errors++; $display("FAIL single c1 data got %h expected %h", {out_a1, out_b1}, 16'h5AA5);
      end
      checks++;
      if ({out_valid1, busy1, done1, in_ready1} !== 4'b1110) begin
         errors++; $display("FAIL single c1 flags got %b expected %b", {out_valid1, busy1, done1, in_ready1}, 4'b1110);
      end
      step();
      checks++;
      if ({out_a1, out_b1, out_valid1, busy1, done1, in_ready1} !== 20'h0_0001) begin
         errors++; $display("FAIL single c2 got %h expected %h",
            {out_a1, out_b1, out_valid1, busy1, done1, in_ready1}, 20'h0_0001);
      end
   endtask

   task automatic test_tall_flush();
      logic [31:0] ed [1:4] = '{32'h000001_0B, 32'h000200_00, 32'h030000_00, 32'h0};
      logic [3:0]  ef [1:4] = '{4'b1100, 4'b1100, 4'b1110, 4'b0001};
      in_valid3 = 1'b1; in_a3 = 24'h030201; in_b3 = 8'h0B;
      for (int c = 1; c <= 4; c++) begin
         step();
         in_valid3 = 1'b0; in_a3 = 24'h0; in_b3 = 8'h0;
         checks++;
         if ({out_a3, out_b3} !== ed[c]) begin
            errors++; $display("FAIL tall c%0d data got %h expected %h", c, {out_a3, out_b3}, ed[c]);
         end
         checks++;
         if ({out_valid3, busy3, done3, in_ready3} !== ef[c]) begin
            errors++; $display("FAIL tall c%0d flags got %b expected %b", c, {out_valid3, busy3, done3, in_ready3}, ef[c]);
         end
      end
   endtask

   initial begin
      in_valid = 1'b0;  in_a = '0;  in_b = '0;
      in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0;
      in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0;
      test_reset();
      test_back_to_back(1'b0, "back_to_back");
      test_bubble();
      test_back_to_back(1'b1, "ignore_busy");
      test_back_to_back(1'b0, "after_ignore");
      test_reset_mid_frame();
      test_single_lane();
      test_tall_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
